fft64_frame_loader: RTL and testbench

Serial-to-parallel frame loader feeding the first radix-2 stage of the 64-point FFT. Accepts one complex sample per cycle over a valid/ready stream and assembles 64 consecutive samples into a natural-order frame. Presents the frame as flattened 64-lane re/im buses with a frame-level valid/ready handshake. Double buffering lets capture of frame k+1 overlap consumption of frame k.

---
 rtl/fft64_pkg.sv | 15 +
 rtl/fft64_frame_bank.sv | 35 +++
 rtl/fft64_frame_loader.sv | 135 +++++++++++++
 tb/tb_fft64_frame_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft64_pkg.sv
// Shared constants and types for the 64-point FFT datapath.
package fft64_pkg;

    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;
    localparam int FFT_WIDTH = 16;

    // Lifecycle of one frame buffer inside the loader.
    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/fft64_frame_bank.sv
// One 64-lane complex frame buffer: indexed single-lane write, whole-frame
// flattened read-out. Lane i occupies bits [(i+1)*WIDTH-1 : i*WIDTH].
module fft64_frame_bank
    import fft64_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [FFT_LOG2N-1:0]       wr_idx,
    input  logic [WIDTH-1:0]           wr_re,
    input  logic [WIDTH-1:0]           wr_im,
    output logic [WIDTH*FFT_N-1:0]     rd_re,
    output logic [WIDTH*FFT_N-1:0]     rd_im
);

    logic [FFT_N-1:0][WIDTH-1:0] lane_re;
    logic [FFT_N-1:0][WIDTH-1:0] lane_im;

    // Lane storage; cleared on reset so no stale data survives a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_re <= '0;
            lane_im <= '0;
        end else if (wr_en) begin
            lane_re[wr_idx] <= wr_re;
            lane_im[wr_idx] <= wr_im;
        end
    end

    assign rd_re = lane_re;
    assign rd_im = lane_im;

endmodule

// File: rtl/fft64_frame_loader.sv
// Serial-to-parallel frame loader for the 64-point FFT front end.
// Optional feature macro: FFT64_LOADER_PINGPONG_EN
//   defined   -> two banks, capture of frame k+1 overlaps consumption of k
//   undefined -> single bank, input stalls while a full frame waits
module fft64_frame_loader
    import fft64_pkg::*;
#(
    parameter int WIDTH = FFT_WIDTH,
    parameter int N     = FFT_N
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_re,
    input  logic [WIDTH-1:0]       in_im,
    input  logic                   in_last,
    output logic [WIDTH*N-1:0]     frame_re,
    output logic [WIDTH*N-1:0]     frame_im,
    output logic                   frame_valid,
    input  logic                   frame_ready,
    output logic                   frame_err
);

`ifdef FFT64_LOADER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    localparam logic [FFT_LOG2N-1:0] LAST_IDX = FFT_LOG2N'(N - 1);

    bank_state_t                   state [NB];
    logic [NB-1:0]                 full;
    logic [NB-1:0]                 wsel;      // one-hot write bank
    logic [NB-1:0]                 rsel;      // one-hot read bank
    logic [NB-1:0][WIDTH*N-1:0]    bank_re;
    logic [NB-1:0][WIDTH*N-1:0]    bank_im;
    logic [FFT_LOG2N-1:0]          wr_idx;

    logic accept, consume, at_last, bad, done;

    assign accept  = in_valid & in_ready;
    assign consume = frame_valid & frame_ready;
    assign at_last = (wr_idx == LAST_IDX);
    // in_last must coincide exactly with the final lane
    assign bad     = accept & (in_last ^ at_last);
    assign done    = accept & at_last & in_last;

    assign in_ready    = ~|(wsel & full);
    assign frame_valid = |(rsel & full);

`ifdef FFT64_LOADER_PINGPONG_EN
    logic wr_bank, rd_bank;

    assign wsel = {wr_bank, ~wr_bank};
    assign rsel = {rd_bank, ~rd_bank};

    // Banks fill and drain in the same order, so toggling each pointer
    // keeps the read pointer on the oldest full bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (done)    wr_bank <= ~wr_bank;
            if (consume) rd_bank <= ~rd_bank;
        end
    end
`else
    assign wsel = 1'b1;
    assign rsel = 1'b1;
`endif

    genvar b;
    generate
        for (b = 0; b < NB; b++) begin : g_bank
            assign full[b] = (state[b] == BANK_FULL);

            fft64_frame_bank #(.WIDTH(WIDTH)) u_bank (
                .clk    (clk),
                .rst    (rst),
                .wr_en  (accept & wsel[b]),
                .wr_idx (wr_idx),
                .wr_re  (in_re),
                .wr_im  (in_im),
                .rd_re  (bank_re[b]),
                .rd_im  (bank_im[b])
            );
        end
    endgenerate

    // Per-bank lifecycle. The read bank is full and the write bank is not,
    // so a consume and an accept never target the same bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NB; i++) state[i] <= BANK_EMPTY;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (consume && rsel[i])
                    state[i] <= BANK_EMPTY;
                else if (accept && wsel[i])
                    state[i] <= bad  ? BANK_EMPTY :
                                done ? BANK_FULL  : BANK_FILLING;
            end
        end
    end

    // Write lane index; a framing error restarts capture at lane 0.
    always_ff @(posedge clk) begin
        if (rst)
            wr_idx <= '0;
        else if (accept)
            wr_idx <= bad ? '0 : wr_idx + 1'b1;
    end

    // Framing error pulse, one cycle after the offending acceptance.
    always_ff @(posedge clk) begin
        if (rst) frame_err <= 1'b0;
        else     frame_err <= bad;
    end

    // Read-out mux: AND-OR select of the read bank.
    always_comb begin
        frame_re = '0;
        frame_im = '0;
        for (int i = 0; i < NB; i++) begin
            if (rsel[i]) begin
                frame_re = frame_re | bank_re[i];
                frame_im = frame_im | bank_im[i];
            end
        end
    end

endmodule

// File: tb/tb_fft64_frame_loader.sv
// Scoreboard bench for fft64_frame_loader. Works in both builds
// (FFT64_LOADER_PINGPONG_EN defined or not).
module tb_fft64_frame_loader;

    localparam int W  = 16;
    localparam int NS = 64;
`ifdef FFT64_LOADER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_re;
    logic [W-1:0]      in_im;
    logic              in_last;
    logic [W*NS-1:0]   frame_re;
    logic [W*NS-1:0]   frame_im;
    logic              frame_valid;
    logic              frame_ready;
    logic              frame_err;

    int total = 0;
    int bad   = 0;

    fft64_frame_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_re       (in_re),
        .in_im       (in_im),
        .in_last     (in_last),
        .frame_re    (frame_re),
        .frame_im    (frame_im),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frames waiting downstream are a simple count; the loader can hold NB.
    logic [W*NS-1:0] expq_re[$];
    logic [W*NS-1:0] expq_im[$];
    logic [W*NS-1:0] cur_re, cur_im;
    int   cur_n  = 0;
    int   m_pend = 0;
    logic m_err  = 1'b0;
    bit   m_acc, m_cons;

    always @(posedge clk) begin
        if (rst) begin
            cur_n  = 0;
            m_pend = 0;
            m_err  = 1'b0;
            expq_re.delete();
            expq_im.delete();
        end else begin
            m_acc  = in_valid && (m_pend < NB);
            m_cons = frame_ready && (m_pend > 0);
            m_err  = 1'b0;
            if (m_cons) m_pend--;
            if (m_acc) begin
                cur_re[cur_n*W +: W] = in_re;
                cur_im[cur_n*W +: W] = in_im;
                if (in_last != (cur_n == NS-1)) begin
                    m_err = 1'b1;
                    cur_n = 0;
                end else if (cur_n == NS-1) begin
                    expq_re.push_back(cur_re);
                    expq_im.push_back(cur_im);
                    m_pend++;
                    cur_n = 0;
                end else begin
                    cur_n++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        chk("in_ready",    in_ready,    (m_pend < NB));
        chk("frame_valid", frame_valid, (m_pend > 0));
        chk("frame_err",   frame_err,   m_err);
        if (frame_valid) begin
            if (expq_re.size() == 0) begin
                total++; bad++;
                $display("FAIL frame_unexpected: got frame_valid=1 expected no pending frame");
            end else begin
                int bl = -1;
                for (int i = NS-1; i >= 0; i--)
                    if (frame_re[i*W +: W] !== expq_re[0][i*W +: W] ||
                        frame_im[i*W +: W] !== expq_im[0][i*W +: W]) bl = i;
                total++;
                if (bl >= 0) begin
                    bad++;
                    $display("FAIL frame_data lane %0d: got re=%h im=%h expected re=%h im=%h",
                             bl, frame_re[bl*W +: W], frame_im[bl*W +: W],
                             expq_re[0][bl*W +: W], expq_im[0][bl*W +: W]);
                end
                if (frame_ready) begin
                    void'(expq_re.pop_front());
                    void'(expq_im.pop_front());
                end
            end
        end
    end

    // ---------------- driver ----------------
    int gap_pct = 0;

    task automatic put(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
        in_valid = 1'b1; in_re = re; in_im = im; in_last = last;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0; in_last = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        total++; bad++;
        $display("FAIL put_timeout: got in_ready=0 for 2000 cycles expected acceptance");
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // n samples; in_last on index last_at (-1: never); ramp data or random
    task automatic send(input int n, input int last_at, input int base, input bit rnd);
        logic [W-1:0] re, im;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                re = W'($urandom); im = W'($urandom);
            end else begin
                re = W'(base + i); im = W'(-(base + i));
            end
            while ($urandom_range(99) < gap_pct) begin
                @(posedge clk); #1;
            end
            put(re, im, (i == last_at));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    bit sdone;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_in_ready",    in_ready,    1'b1);
        chk("reset_frame_valid", frame_valid, 1'b0);
        chk("reset_frame_err",   frame_err,   1'b0);
        chk("reset_frame_re",    {31'b0, |frame_re}, 32'd0);
        chk("reset_frame_im",    {31'b0, |frame_im}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ramp frame, latency and lane spot check
        frame_ready = 1'b1;
        send(NS, NS-1, 0, 1'b0);
        @(negedge clk);
        chk("latency_valid", frame_valid, 1'b1);
        chk("lane5_re", frame_re[5*W +: W], 16'd5);
        chk("lane5_im", frame_im[5*W +: W], 16'hFFFB);
        @(posedge clk); #1;

        // three back-to-back random frames
        repeat (3) send(NS, NS-1, 0, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // two frames loaded with downstream stalled, then single releases
        frame_ready = 1'b0;
        fork
            begin send(NS, NS-1, 0, 1'b1); send(NS, NS-1, 0, 1'b1); end
            begin
                repeat (150) @(posedge clk);
                #1 frame_ready = 1'b1;
                @(posedge clk); #1 frame_ready = 1'b0;
                repeat (100) @(posedge clk);
                #1 frame_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // framing errors: early in_last, missing in_last, then clean frame
        send(41, 40, 0, 1'b1);
        send(NS, -1, 0, 1'b1);
        send(NS, NS-1, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;

        // reset mid-frame, then a fresh ramp from 100
        send(30, -1, 7, 1'b0);
        do_reset();
        send(NS, NS-1, 100, 1'b0);
        @(negedge clk);
        chk("after_reset_lane0_re", frame_re[W-1:0], 16'd100);
        @(posedge clk); #1;

        // reset with a complete frame pending
        frame_ready = 1'b0;
        send(NS, NS-1, 0, 1'b1);
        do_reset();
        @(negedge clk);
        chk("pending_reset_valid", frame_valid, 1'b0);
        @(posedge clk); #1;
        frame_ready = 1'b1;

        // random gaps and random downstream backpressure
        gap_pct = 25;
        sdone = 1'b0;
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    if (f == 3) send(NS, $urandom_range(62), 0, 1'b1);
                    send(NS, NS-1, 0, 1'b1);
                end
                sdone = 1'b1;
            end
            begin
                while (!sdone) begin
                    frame_ready = 1'($urandom_range(1));
                    @(posedge clk); #1;
                end
                frame_ready = 1'b1;
            end
        join
        gap_pct = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", expq_re.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
